sym_fir_core: RTL and testbench
===============================

Name: sym_fir_core

Overview:
- Time-multiplexed symmetric FIR filter. Sits directly downstream of the serial-to-parallel frame buffering stage.
- Consumes one signed sample per valid/ready handshake and shifts it into an N_TAPS delay line.
- Exploits coefficient symmetry: one pre-adder and one multiplier, N_TAPS/2 MAC cycles per sample.
- Presents a full-precision result on a valid/ready output port to the next stage.

Parameters:
- DATA_W, 16, input sample width (signed two's complement)
- COEF_W, 16, coefficient width (signed)
- N_TAPS, 16, filter length; must be even and >= 2
- ACC_W, DATA_W+COEF_W+$clog2(N_TAPS), accumulator/output width (full precision, no overflow possible)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- in_valid  input  1  sample available
- in_ready  output  1  core can accept a sample
- in_data  input  DATA_W  signed sample
- coef  input  (N_TAPS/2)*COEF_W  unique half of coefficients; c[k] = coef[k*COEF_W +: COEF_W], k=0..N_TAPS/2-1
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_data  output  ACC_W  signed filter output

Behaviour:
- Reset (rst=0, async):
  - Delay line, coefficient register, acc and idx cleared to 0.
  - State=IDLE; out_valid=0; out_data=0.
  - in_ready=0 while rst=0, then 1 from the first cycle after deassertion.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready (edge E0): line[0]<=in_data, line[k]<=line[k-1]; coef latched into coefficient register; acc<=0; idx<=0; ->MAC.
- MAC:
  - in_ready=0; in_valid ignored, no sample lost or duplicated.
  - Each edge: acc += (sext(line[idx]) + sext(line[N_TAPS-1-idx])) * c[idx]; idx++.
  - Pre-add width is DATA_W+1; product is sign-extended to ACC_W.
  - On the edge where idx==N_TAPS/2-1: ->OUT.
- OUT:
  - out_valid=1, out_data=acc; both held stable until out_ready=1.
  - On out_valid&&out_ready: ->IDLE; out_valid drops next cycle. out_data keeps its last value.
- Latency: out_valid rises at edge E0+N_TAPS/2.
- Throughput: with out_ready held at 1, one sample per N_TAPS/2+2 cycles.
- Backpressure: out_ready=0 stalls indefinitely in OUT. The delay line is not modified and in_ready stays 0.
- Coefficient changes on coef take effect only at the next accepted sample, never mid-computation.
- Reset mid-MAC or mid-OUT: partial result discarded, all state cleared, no out_valid pulse.
- idx range is 0..N_TAPS/2-1; it never wraps within a computation and is cleared on accept.

Decomposition:
- Package sym_fir_pkg:
  - State enum (IDLE, MAC, OUT).
  - Default width constants.
  - Derived localparams HALF_TAPS=N_TAPS/2, IDX_W=$clog2(HALF_TAPS) (min 1), PRE_W=DATA_W+1.
- One sub-module sym_fir_preadd_mult: combinational (a+b)*c with signed extension to ACC_W. Instantiated once in sym_fir_core.
- FSM, delay line, coefficient register and accumulator live in sym_fir_core.

Test Plan:
- Impulse: c[0..7]=1..8, out_ready=1; feed 1 then fifteen 0s -> outputs 1,2,3,4,5,6,7,8,8,7,6,5,4,3,2,1. Each out_valid lands exactly 8 cycles after its accept edge.
- Step/DC: c[k]=1, feed 16 samples of 100 -> outputs 100,200,…,1600; 17th sample of 100 -> 1600.
- Extremes: all c=-32768; feed 16 samples of -32768 -> final output +2^34 (17179869184), exactly representable in ACC_W=36 with no overflow.
- Backpressure: out_ready=0 for 20 cycles with in_valid=1 throughout -> out_data stable and in_ready=0 throughout. Only one extra sample is accepted after out_ready pulses.
- Coefficient change: change coef during MAC -> current output uses the old coefficients, next output uses the new ones.
- Reset mid-MAC: drop rst to 0 at the 4th MAC cycle -> out_valid=0 and out_data=0 immediately. After release, the impulse test reproduces the first test's sequence exactly, confirming the delay line was cleared.

Source files
------------

// File: rtl/sym_fir_pkg.sv
// Shared types, default widths and width helpers for the symmetric FIR core.
package sym_fir_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StOut
    } fir_state_e;

    // Index width for a counter over n entries; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The pre-adder sum of two DATA_W samples needs one extra bit.
    function automatic int unsigned pre_width(input int unsigned data_w);
        return data_w + 1;
    endfunction

    localparam int unsigned DEF_DATA_W    = 16;
    localparam int unsigned DEF_COEF_W    = 16;
    localparam int unsigned DEF_N_TAPS    = 16;
    localparam int unsigned DEF_HALF_TAPS = DEF_N_TAPS / 2;
    localparam int unsigned DEF_IDX_W     = idx_width(DEF_HALF_TAPS);
    localparam int unsigned DEF_PRE_W     = pre_width(DEF_DATA_W);
    localparam int unsigned DEF_ACC_W     = DEF_DATA_W + DEF_COEF_W + $clog2(DEF_N_TAPS);

endpackage

// File: rtl/sym_fir_preadd_mult.sv
// Combinational pre-add and multiply: (a + b) * c, sign-extended to ACC_W.
module sym_fir_preadd_mult
    import sym_fir_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned COEF_W = DEF_COEF_W,
    parameter int unsigned ACC_W  = DEF_ACC_W
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic signed [COEF_W-1:0] c,
    output logic signed [ACC_W-1:0]  p
);

    localparam int unsigned PRE_W  = pre_width(DATA_W);
    localparam int unsigned PROD_W = PRE_W + COEF_W;

    logic signed [PRE_W-1:0]  pre;
    logic signed [PROD_W-1:0] prod;

    // Widen before adding/multiplying so neither step can overflow.
    always_comb begin
        pre  = PRE_W'(a) + PRE_W'(b);
        prod = PROD_W'(pre) * PROD_W'(c);
        p    = ACC_W'(prod);
    end

endmodule

// File: rtl/sym_fir_core.sv
// Time-multiplexed symmetric FIR: one pre-adder/multiplier, N_TAPS/2 MAC cycles per sample.
module sym_fir_core
    import sym_fir_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned COEF_W = DEF_COEF_W,
    parameter int unsigned N_TAPS = DEF_N_TAPS,
    parameter int unsigned ACC_W  = DATA_W + COEF_W + $clog2(N_TAPS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [DATA_W-1:0]       in_data,
    input  logic [(N_TAPS/2)*COEF_W-1:0]   coef,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [ACC_W-1:0]        out_data
);

    localparam int unsigned HALF_TAPS = N_TAPS / 2;
    localparam int unsigned IDX_W     = idx_width(HALF_TAPS);
    localparam int unsigned LINE_W    = idx_width(N_TAPS);

    fir_state_e state_q, state_d;

    logic signed [DATA_W-1:0]        line_q [N_TAPS];
    logic [HALF_TAPS*COEF_W-1:0]     coef_q;
    logic signed [COEF_W-1:0]        c_arr  [HALF_TAPS];
    logic signed [ACC_W-1:0]         acc_q;
    logic signed [ACC_W-1:0]         out_q;
    logic signed [ACC_W-1:0]         prod;
    logic [IDX_W-1:0]                idx_q;
    logic [LINE_W-1:0]               mir_idx;
    logic                            accept;
    logic                            last;

    for (genvar k = 0; k < HALF_TAPS; k++) begin : g_coef
        assign c_arr[k] = coef_q[k*COEF_W +: COEF_W];
    end

    // Handshake qualifiers and the mirrored tap paired with idx.
    always_comb begin
        in_ready  = rst && (state_q == StIdle);
        out_valid = (state_q == StOut);
        out_data  = out_q;
        accept    = in_valid && in_ready;
        last      = (idx_q == IDX_W'(HALF_TAPS - 1));
        mir_idx   = LINE_W'(N_TAPS - 1) - LINE_W'(idx_q);
    end

    sym_fir_preadd_mult #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_preadd_mult (
        .a (line_q[idx_q]),
        .b (line_q[mir_idx]),
        .c (c_arr[idx_q]),
        .p (prod)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StMac;
            StMac:   if (last) state_d = StOut;
            StOut:   if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Delay line, coefficient snapshot, accumulator and result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_TAPS; k++) begin
                line_q[k] <= '0;
            end
            coef_q <= '0;
            acc_q  <= '0;
            out_q  <= '0;
            idx_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        line_q[0] <= in_data;
                        for (int k = 1; k < N_TAPS; k++) begin
                            line_q[k] <= line_q[k-1];
                        end
                        coef_q <= coef;
                        acc_q  <= '0;
                        idx_q  <= '0;
                    end
                end
                StMac: begin
                    acc_q <= acc_q + prod;
                    // Hold idx at the final tap rather than wrapping.
                    if (last) begin
                        out_q <= acc_q + prod;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sym_fir_core.sv
// Scoreboard bench for sym_fir_core with directed vectors and hand-derived expectations.
module tb_sym_fir_core;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int N_TAPS = 16;
    localparam int HALF   = N_TAPS / 2;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(N_TAPS);

    logic                         clk;
    logic                         rst;
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_W-1:0]     in_data;
    logic [HALF*COEF_W-1:0]       coef;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [ACC_W-1:0]      out_data;

    sym_fir_core #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .N_TAPS (N_TAPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .coef      (coef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    longint exp_q[$];
    int     lat_q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     acc_cnt = 0;
    bit     prev_ov = 1'b0;

    int imp_exp [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 7, 6, 5, 4, 3, 2, 1};

    task automatic check(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic logic [HALF*COEF_W-1:0] coef_ramp();
        logic [HALF*COEF_W-1:0] v;
        for (int k = 0; k < HALF; k++) v[k*COEF_W +: COEF_W] = COEF_W'(k + 1);
        return v;
    endfunction

    function automatic logic [HALF*COEF_W-1:0] coef_all(input int val);
        logic [HALF*COEF_W-1:0] v;
        for (int k = 0; k < HALF; k++) v[k*COEF_W +: COEF_W] = COEF_W'(val);
        return v;
    endfunction

    // Offer one sample; push its expected result when the handshake is seen.
    task automatic send(input int d, input longint expv, input bit chk);
        int n = 0;
        in_data  = DATA_W'(d);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("send_timeout");
        else if (chk) exp_q.push_back(expv);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic run_impulse();
        coef = coef_ramp();
        for (int i = 0; i < 16; i++) send((i == 0) ? 1 : 0, longint'(imp_exp[i]), 1'b1);
        wait_drain();
    endtask

    initial begin
        longint e;
        int     cnt0;
        int     n;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        coef      = '0;

        // Monitor: counts accepts, checks latency and pops the scoreboard on each handshake.
        fork
            forever begin
                @(negedge clk);
                if (rst) begin
                    if (in_valid && in_ready) begin
                        acc_cnt++;
                        lat_q.push_back(cyc + 1);
                    end
                    if (out_valid && !prev_ov) begin
                        if (lat_q.size() == 0) fail_now("latency_no_accept");
                        else check("latency", longint'(cyc - lat_q.pop_front()), longint'(HALF));
                    end
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) fail_now("unexpected_output");
                        else check("out_data", longint'(out_data), exp_q.pop_front());
                    end
                    prev_ov = out_valid;
                end else begin
                    prev_ov = 1'b0;
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;

        // Impulse
        run_impulse();

        // Step / DC
        coef = coef_all(1);
        for (int i = 0; i < 17; i++) send(100, longint'(100 * ((i + 1 > 16) ? 16 : i + 1)), 1'b1);
        wait_drain();

        // Extremes: line starts at all 100; y_n = n*2^30 - 3276800*(16-n)
        coef = coef_all(-32768);
        for (int i = 1; i <= 16; i++) begin
            e = longint'(i) * 64'sd1073741824 - 64'sd3276800 * longint'(16 - i);
            send(-32768, e, 1'b1);
        end
        wait_drain();

        // Coefficient change during MAC
        coef = coef_all(1);
        send(0, -64'sd491520, 1'b1);
        repeat (2) @(posedge clk);
        #1 coef = coef_all(2);
        send(0, -64'sd917504, 1'b1);
        wait_drain();

        // Backpressure
        out_ready = 1'b0;
        send(0, -64'sd851968, 1'b1);
        in_data  = '0;
        in_valid = 1'b1;
        exp_q.push_back(-64'sd786432);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now("bp_out_valid_timeout");
        cnt0 = acc_cnt;
        for (int i = 0; i < 20; i++) begin
            check("bp_out_valid", longint'(out_valid), 1);
            check("bp_out_data", longint'(out_data), -64'sd851968);
            check("bp_in_ready", longint'(in_ready), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("bp_extra_accepts", longint'(acc_cnt - cnt0), 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Reset mid-MAC, then impulse again on a cleared delay line
        coef = coef_ramp();
        send(5, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_out_data", longint'(out_data), 0);
        check("midrst_in_ready", longint'(in_ready), 0);
        exp_q.delete();
        lat_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        run_impulse();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
